// File: rtl/fifo_p_w8to16_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_p_w8to16_pkg
// Purpose  : Shared widths, FIFO entry layout and packer state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package fifo_p_w8to16_pkg;

    localparam int DIN_W     = 8;
    localparam int DOUT_W    = 16;
    localparam int ENTRY_W   = 19;
    localparam int ENTRY_SOP = 18;
    localparam int ENTRY_EOP = 17;
    localparam int ENTRY_MTY = 16;

    // Field order matches ENTRY_SOP/EOP/MTY bit indices
    typedef struct packed {
        logic              sop;
        logic              eop;
        logic              mty;
        logic [DOUT_W-1:0] data;
    } entry_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EVEN = 2'd1;
    localparam logic [1:0] ST_ODD  = 2'd2;
    localparam logic [1:0] ST_DROP = 2'd3;

    function automatic entry_t make_entry(input logic sop, input logic eop,
                                          input logic mty,
                                          input logic [DOUT_W-1:0] data);
        entry_t e;
        e.sop  = sop;
        e.eop  = eop;
        e.mty  = mty;
        e.data = data;
        return e;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_p_w8to16_pkt_sfifo.sv
`default_nettype none
// ============================================================================
// Module   : pkt_sfifo
// Purpose  : Synchronous FIFO with fill level; concurrent read/write allowed.
// Revision : 1.0 - initial release
// ============================================================================
module pkt_sfifo #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 19
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     rd,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   usedw
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             rd_en;
    logic             wr_en;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_en = rd && !empty;
    // A pop in the same cycle frees the slot a write to a full FIFO needs
    assign wr_en = wr && (!full || rd_en);
    assign usedw = wr_ptr - rd_ptr;
    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule
`default_nettype wire

// File: rtl/fifo_p_w8to16.sv
`default_nettype none
// ============================================================================
// Module   : fifo_p_w8to16
// Purpose  : Packet FIFO packing a byte stream into big-endian 16-bit words,
//            with whole-packet admission control and registered output.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_p_w8to16
    import fifo_p_w8to16_pkg::*;
#(
    parameter int DEPTH         = 256,
    parameter int MAX_PKT_WORDS = 72
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DIN_W-1:0]  din,
    input  logic              din_vld,
    input  logic              din_sop,
    input  logic              din_eop,
    input  logic              b_rdy,
    output logic [DOUT_W-1:0] dout,
    output logic              dout_vld,
    output logic              dout_sop,
    output logic              dout_eop,
    output logic              dout_mty
);

    localparam int AW = $clog2(DEPTH);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [DIN_W-1:0] hi;
    logic             first;
    logic             wr_req;
    entry_t           wentry;
    logic [ENTRY_W-1:0] rdata;
    entry_t           rentry;
    logic             full;
    logic             empty;
    logic [AW:0]      usedw;
    logic [AW:0]      free_words;
    logic             admit;
    logic             pop;

    assign free_words = (AW+1)'(DEPTH) - usedw;
    assign admit      = (free_words >= (AW+1)'(MAX_PKT_WORDS));
    assign pop        = b_rdy && !empty;
    assign rentry     = rdata;

    // ---------------- packer FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // ---------------- packer FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        if (din_vld) begin
            if (din_sop) begin
                if (din_eop)    state_nxt = ST_IDLE;
                else if (admit) state_nxt = ST_ODD;
                else            state_nxt = ST_DROP;
            end else begin
                case (state)
                    ST_EVEN: state_nxt = din_eop ? ST_IDLE : ST_ODD;
                    ST_ODD:  state_nxt = din_eop ? ST_IDLE : ST_EVEN;
                    ST_DROP: if (din_eop) state_nxt = ST_IDLE;
                    default: state_nxt = state;
                endcase
            end
        end
    end

    // ---------------- packer FSM: write outputs ----------------
    always_comb begin
        wr_req = 1'b0;
        wentry = '0;
        if (din_vld) begin
            if (din_sop) begin
                if (din_eop && admit) begin
                    wr_req = 1'b1;
                    wentry = make_entry(1'b1, 1'b1, 1'b1, {din, 8'h00});
                end
            end else begin
                case (state)
                    ST_EVEN: begin
                        if (din_eop) begin
                            wr_req = 1'b1;
                            wentry = make_entry(1'b0, 1'b1, 1'b1, {din, 8'h00});
                        end
                    end
                    ST_ODD: begin
                        wr_req = 1'b1;
                        wentry = make_entry(first, din_eop, 1'b0, {hi, din});
                    end
                    default: begin
                        wr_req = 1'b0;
                    end
                endcase
            end
        end
    end

    // High byte holder; a new sop overwrites any pending byte of an open packet
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi    <= '0;
            first <= 1'b0;
        end else if (din_vld && (din_sop || state == ST_EVEN)) begin
            hi    <= din;
            first <= din_sop;
        end
    end

    pkt_sfifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_sfifo (
        .clk   (clk),
        .rst   (rst),
        .wr    (wr_req && (!full || pop)),
        .wdata (wentry),
        .rd    (b_rdy),
        .rdata (rdata),
        .full  (full),
        .empty (empty),
        .usedw (usedw)
    );

    // Output stage: flags only qualify a valid word, data holds between words
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout     <= '0;
            dout_vld <= 1'b0;
            dout_sop <= 1'b0;
            dout_eop <= 1'b0;
            dout_mty <= 1'b0;
        end else begin
            dout_vld <= pop;
            if (pop) begin
                dout     <= rentry.data;
                dout_sop <= rentry.sop;
                dout_eop <= rentry.eop;
                dout_mty <= rentry.mty;
            end else begin
                dout_sop <= 1'b0;
                dout_eop <= 1'b0;
                dout_mty <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_p_w8to16.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_p_w8to16
// Purpose  : Scoreboard bench for the 8->16 packet FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_p_w8to16;

    typedef logic [7:0]  bq_t [$];
    typedef logic [18:0] exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  din;
    logic        din_vld;
    logic        din_sop;
    logic        din_eop;
    logic        b_rdy;
    logic [15:0] dout;
    logic        dout_vld;
    logic        dout_sop;
    logic        dout_eop;
    logic        dout_mty;

    exp_t exp_q [$];
    int   errors = 0;
    int   checks = 0;
    int   rdy_mode = 0;   // 0: hold low, 1: hold high, 2: random

    always #5 clk = ~clk;

    fifo_p_w8to16 dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .din_vld  (din_vld),
        .din_sop  (din_sop),
        .din_eop  (din_eop),
        .b_rdy    (b_rdy),
        .dout     (dout),
        .dout_vld (dout_vld),
        .dout_sop (dout_sop),
        .dout_eop (dout_eop),
        .dout_mty (dout_mty)
    );

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 2) b_rdy = 1'($urandom_range(0, 1));
            else               b_rdy = (rdy_mode == 1);
        end
    end

    // Monitor: every presented word is popped against the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                checks++;
                if (dout_vld) begin
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_word got={sop,eop,mty,data}=%h required=none",
                                 {dout_sop, dout_eop, dout_mty, dout});
                    end else begin
                        e = exp_q.pop_front();
                        if ({dout_sop, dout_eop, dout_mty, dout} !== e) begin
                            errors++;
                            $display("FAIL word got={sop,eop,mty,data}=%h required=%h",
                                     {dout_sop, dout_eop, dout_mty, dout}, e);
                        end
                    end
                end else if ({dout_sop, dout_eop, dout_mty} !== 3'b000) begin
                    errors++;
                    $display("FAIL idle_flags got=%b required=000", {dout_sop, dout_eop, dout_mty});
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic drive_byte(input logic [7:0] b, input logic sop, input logic eop);
        din     = b;
        din_vld = 1'b1;
        din_sop = sop;
        din_eop = eop;
        tick();
        din_vld = 1'b0;
        din_sop = 1'b0;
        din_eop = 1'b0;
        din     = 8'($urandom);
    endtask

    // Reference packing: big-endian pairs, odd tail padded with mty=1
    task automatic expect_pkt(input bq_t b);
        int n = b.size();
        for (int i = 0; i < n; i += 2) begin
            if (i + 1 < n) exp_q.push_back({(i == 0), (i + 1 == n - 1), 1'b0, b[i], b[i+1]});
            else           exp_q.push_back({(i == 0), 1'b1, 1'b1, b[i], 8'h00});
        end
    endtask

    task automatic send_pkt(input bq_t b, input int gap_max, input bit model);
        if (model) expect_pkt(b);
        for (int i = 0; i < b.size(); i++) begin
            if (gap_max > 0) idle($urandom_range(0, gap_max));
            drive_byte(b[i], (i == 0), (i == b.size() - 1));
        end
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout got=%0d words pending required=0", exp_q.size());
            exp_q.delete();
        end
        idle(4);
    endtask

    task automatic check_outputs_zero(input string name);
        checks++;
        if ({dout_vld, dout_sop, dout_eop, dout_mty, dout} !== 20'h0) begin
            errors++;
            $display("FAIL %s got={vld,sop,eop,mty,data}=%h required=0", name,
                     {dout_vld, dout_sop, dout_eop, dout_mty, dout});
        end
    endtask

    function automatic bq_t mk(input int n, input int base);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(8'(base + i * 7));
        return q;
    endfunction

    initial begin
        bq_t q;
        int  n;
        rst = 1'b1; din = '0; din_vld = 1'b0; din_sop = 1'b0; din_eop = 1'b0; b_rdy = 1'b0;
        idle(3);
        check_outputs_zero("reset_outputs");
        rst = 1'b0;
        idle(2);
        check_outputs_zero("post_reset_outputs");
        rdy_mode = 1;
        idle(2);

        // 4-byte packet, contiguous
        exp_q.push_back({1'b1, 1'b0, 1'b0, 16'h1122});
        exp_q.push_back({1'b0, 1'b1, 1'b0, 16'h3344});
        q = {8'h11, 8'h22, 8'h33, 8'h44};
        send_pkt(q, 0, 0);
        wait_drain(50);

        // 3-byte packet with valid gaps
        exp_q.push_back({1'b1, 1'b0, 1'b0, 16'hAABB});
        exp_q.push_back({1'b0, 1'b1, 1'b1, 16'hCC00});
        q = {8'hAA, 8'hBB, 8'hCC};
        send_pkt(q, 3, 0);
        wait_drain(50);

        // 1-byte packet
        exp_q.push_back({1'b1, 1'b1, 1'b1, 16'h5A00});
        q = {8'h5A};
        send_pkt(q, 0, 0);
        wait_drain(50);

        // sop inside an open packet restarts; stray bytes outside a packet ignored
        exp_q.push_back({1'b1, 1'b0, 1'b0, 16'h0102});
        exp_q.push_back({1'b1, 1'b1, 1'b0, 16'h0A0B});
        drive_byte(8'h01, 1'b1, 1'b0);
        drive_byte(8'h02, 1'b0, 1'b0);
        drive_byte(8'h03, 1'b0, 1'b0);
        drive_byte(8'h0A, 1'b1, 1'b0);
        drive_byte(8'h0B, 1'b0, 1'b1);
        drive_byte(8'h77, 1'b0, 1'b0);
        drive_byte(8'h78, 1'b0, 1'b1);
        wait_drain(50);

        // Three 140-byte packets buffered with the sink stalled
        rdy_mode = 0;
        idle(1);
        for (int p = 0; p < 3; p++) send_pkt(mk(140, 16 * p + 3), 0, 1);
        idle(5);
        rdy_mode = 1;
        wait_drain(1000);

        // Admission boundary: 184 used -> admitted, 185 used -> dropped
        rdy_mode = 0;
        idle(1);
        send_pkt(mk(140, 5), 0, 1);
        send_pkt(mk(140, 9), 0, 1);
        send_pkt(mk(88, 13), 0, 1);
        q = {8'hE1, 8'hE2};
        send_pkt(q, 0, 1);
        q = {8'hD1, 8'hD2, 8'hD3};
        send_pkt(q, 1, 0);
        q = {8'hD9};
        send_pkt(q, 0, 0);
        rdy_mode = 1;
        wait_drain(1000);
        q = {8'hF0, 8'hF1, 8'hF2, 8'hF3, 8'hF4};
        send_pkt(q, 0, 1);
        wait_drain(50);

        // Random lengths, valid gaps and sink stalls; keep room so every packet is admitted
        rdy_mode = 2;
        for (int p = 0; p < 25; p++) begin
            int w = 0;
            while (exp_q.size() > 184 && w < 3000) begin
                tick();
                w++;
            end
            if (w >= 3000) begin
                checks++;
                errors++;
                $display("FAIL room_timeout got=%0d pending required<=184", exp_q.size());
            end
            n = $urandom_range(1, 141);
            q.delete();
            for (int i = 0; i < n; i++) q.push_back(8'($urandom));
            send_pkt(q, 2, 1);
        end
        rdy_mode = 1;
        wait_drain(5000);

        // Reset mid-packet while words are streaming out
        rdy_mode = 0;
        idle(1);
        send_pkt(mk(20, 40), 0, 1);
        for (int i = 0; i < 5; i++) drive_byte(8'(8'h90 + i), (i == 0), 1'b0);
        rdy_mode = 1;
        idle(3);
        #3;
        rst = 1'b1;
        #1;
        check_outputs_zero("async_reset_outputs");
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
        idle(20);
        check_outputs_zero("flushed_outputs");
        exp_q.push_back({1'b1, 1'b1, 1'b0, 16'hC33C});
        q = {8'hC3, 8'h3C};
        send_pkt(q, 0, 0);
        wait_drain(50);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
